// File: rtl/vga_pkg.sv
// Shared VGA-pipeline constants: active raster geometry, frame-buffer widths and
// the frame_buffer_writer state encoding.
package vga_pkg;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int FRAME_PIXELS = H_RES * V_RES;
  localparam int DATA_W       = 8;
  localparam int ADDR_W       = 19;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/fb_addr_counter.sv
// Raster position counter: tracks x/y and a linear address that advances in step
// with x, so the address is always y*H_RES+x without a multiplier.
module fb_addr_counter
  import vga_pkg::*;
#(
  parameter int H_RES_P  = H_RES,
  parameter int V_RES_P  = V_RES,
  parameter int ADDR_W_P = ADDR_W,
  parameter int X_W      = $clog2(H_RES_P),
  parameter int Y_W      = $clog2(V_RES_P)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  output logic [ADDR_W_P-1:0] addr,
  output logic                last
);

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;

  assign last = (x == X_W'(H_RES_P - 1)) && (y == Y_W'(V_RES_P - 1));

  // The counter parks on the final pixel instead of wrapping; a clear starts the next frame.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (en && !last) begin
      addr <= addr + 1'b1;
      if (x == X_W'(H_RES_P - 1)) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_buffer_writer.sv
// Writes the ALU pixel stream into a double-buffered frame buffer and swaps the
// display bank only after a complete frame has been written.
module frame_buffer_writer
  import vga_pkg::*;
#(
  parameter int H_RES_P  = H_RES,
  parameter int V_RES_P  = V_RES,
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W_P-1:0] pixel_in,
  input  logic                pixel_in_valido,
  input  logic                frame_start,
  output logic                wr_en,
  output logic [ADDR_W_P-1:0] wr_addr,
  output logic [DATA_W_P-1:0] wr_data,
  output logic                wr_bank,
  output logic                rd_bank,
  output logic                frame_done,
  output logic                busy,
  output logic                err_abort,
  output logic                err_drop
);

  logic [1:0]          state;
  logic [1:0]          next_state;
  logic [ADDR_W_P-1:0] cnt_addr;
  logic                cnt_last;
  logic                last_pix;
  logic                write_now;
  logic                do_swap;
  logic                do_abort;
  logic                do_drop;

  fb_addr_counter #(
    .H_RES_P  (H_RES_P),
    .V_RES_P  (V_RES_P),
    .ADDR_W_P (ADDR_W_P)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (frame_start),
    .en    (write_now),
    .addr  (cnt_addr),
    .last  (cnt_last)
  );

  // A frame_start that lands on the final pixel still lets that pixel through and counts as a completed frame.
  always_comb begin
    last_pix   = (state == WRITE) && pixel_in_valido && cnt_last;
    write_now  = (state == WRITE) && pixel_in_valido && (!frame_start || cnt_last);
    do_swap    = frame_start && ((state == DONE) || last_pix);
    do_abort   = frame_start && (state == WRITE) && !last_pix;
    do_drop    = pixel_in_valido && !write_now;
    next_state = state;
    case (state)
      IDLE:    if (frame_start) next_state = WRITE;
      WRITE:   if (last_pix && !frame_start) next_state = DONE;
      DONE:    if (frame_start) next_state = WRITE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err_abort  <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= (next_state == WRITE);
      wr_en      <= write_now;
      frame_done <= last_pix;
      if (write_now) begin
        wr_addr <= cnt_addr;
        wr_data <= pixel_in;
      end
      if (do_swap) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end
      if (do_abort) err_abort <= 1'b1;
      if (do_drop)  err_drop  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer, using a short 640x8 raster so full
// frames, aborts and bank swaps run in a few thousand cycles.
module tb_frame_buffer_writer;

  localparam int H      = 640;
  localparam int V      = 8;
  localparam int LAST_A = H * V - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pixel_in;
  logic        pixel_in_valido;
  logic        frame_start;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_bank;
  logic        rd_bank;
  logic        frame_done;
  logic        busy;
  logic        err_abort;
  logic        err_drop;

  int passCount  = 0;
  int checkCount = 0;
  int doneCount;

  frame_buffer_writer #(
    .H_RES_P  (H),
    .V_RES_P  (V),
    .DATA_W_P (8),
    .ADDR_W_P (19)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pixel_in        (pixel_in),
    .pixel_in_valido (pixel_in_valido),
    .frame_start     (frame_start),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_bank         (wr_bank),
    .rd_bank         (rd_bank),
    .frame_done      (frame_done),
    .busy            (busy),
    .err_abort       (err_abort),
    .err_drop        (err_drop)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs, then leaves the bench 1 ns past the edge for sampling.
  task automatic applyStimulus(input logic start, input logic valid, input logic [7:0] data);
    frame_start     = start;
    pixel_in_valido = valid;
    pixel_in        = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    pixel_in_valido = 1'b0;
    pixel_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wr_en",      32'(wr_en),      32'd0);
    checkOutput("rst_wr_addr",    32'(wr_addr),    32'd0);
    checkOutput("rst_wr_data",    32'(wr_data),    32'd0);
    checkOutput("rst_wr_bank",    32'(wr_bank),    32'd0);
    checkOutput("rst_rd_bank",    32'(rd_bank),    32'd1);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_err_abort",  32'(err_abort),  32'd0);
    checkOutput("rst_err_drop",   32'(err_drop),   32'd0);
    rst = 1'b0;

    $display("[TB] first pixels");
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("arm_busy",  32'(busy),  32'd1);
    checkOutput("arm_wr_en", 32'(wr_en), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h11);
    checkOutput("p0_en",   32'(wr_en),   32'd1);
    checkOutput("p0_addr", 32'(wr_addr), 32'd0);
    checkOutput("p0_data", 32'(wr_data), 32'h11);
    applyStimulus(1'b0, 1'b1, 8'h22);
    checkOutput("p1_addr", 32'(wr_addr), 32'd1);
    checkOutput("p1_data", 32'(wr_data), 32'h22);
    applyStimulus(1'b0, 1'b1, 8'h33);
    checkOutput("p2_addr", 32'(wr_addr), 32'd2);
    checkOutput("p2_data", 32'(wr_data), 32'h33);
    checkOutput("p2_busy", 32'(busy),    32'd1);

    $display("[TB] first line with gaps");
    for (int i = 3; i <= 640; i++) begin
      if (i % 7 == 0) begin
        applyStimulus(1'b0, 1'b0, 8'hEE);
        checkOutput("gap_wr_en", 32'(wr_en), 32'd0);
      end
      applyStimulus(1'b0, 1'b1, 8'(i));
      checkOutput("line_addr", 32'(wr_addr), 32'(i));
      checkOutput("line_data", 32'(wr_data), 32'(i % 256));
    end

    $display("[TB] rest of frame");
    doneCount = 0;
    for (int i = 641; i <= LAST_A; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i));
      if (frame_done === 1'b1) doneCount++;
      if (i == LAST_A) begin
        checkOutput("last_wr_en",  32'(wr_en),      32'd1);
        checkOutput("last_addr",   32'(wr_addr),    32'(LAST_A));
        checkOutput("last_done",   32'(frame_done), 32'd1);
      end
    end
    checkOutput("done_pulses", 32'(doneCount), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h5A);
    checkOutput("done_state_wr_en", 32'(wr_en),      32'd0);
    checkOutput("done_state_pulse", 32'(frame_done), 32'd0);
    checkOutput("done_state_busy",  32'(busy),       32'd0);
    checkOutput("done_state_drop",  32'(err_drop),   32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("swap_wr_bank", 32'(wr_bank), 32'd1);
    checkOutput("swap_rd_bank", 32'(rd_bank), 32'd0);
    checkOutput("swap_busy",    32'(busy),    32'd1);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    checkOutput("f2_addr", 32'(wr_addr), 32'd0);
    checkOutput("f2_data", 32'(wr_data), 32'hA5);

    $display("[TB] aborted frame");
    for (int i = 1; i < 1000; i++) applyStimulus(1'b0, 1'b1, 8'(i));
    checkOutput("pre_abort_addr",  32'(wr_addr),   32'd999);
    checkOutput("pre_abort_flag",  32'(err_abort), 32'd0);
    applyStimulus(1'b1, 1'b1, 8'h77);
    checkOutput("abort_flag",    32'(err_abort), 32'd1);
    checkOutput("abort_wr_en",   32'(wr_en),     32'd0);
    checkOutput("abort_wr_bank", 32'(wr_bank),   32'd1);
    checkOutput("abort_rd_bank", 32'(rd_bank),   32'd0);
    checkOutput("abort_busy",    32'(busy),      32'd1);
    applyStimulus(1'b0, 1'b1, 8'h88);
    checkOutput("post_abort_addr", 32'(wr_addr), 32'd0);
    checkOutput("post_abort_data", 32'(wr_data), 32'h88);

    $display("[TB] idle drops and coincident start");
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    checkOutput("rst2_abort", 32'(err_abort), 32'd0);
    checkOutput("rst2_busy",  32'(busy),      32'd0);
    applyStimulus(1'b0, 1'b1, 8'h42);
    checkOutput("idle_wr_en", 32'(wr_en),    32'd0);
    checkOutput("idle_drop",  32'(err_drop), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h43);
    checkOutput("idle_wr_en2", 32'(wr_en), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("idle_start_wr_bank", 32'(wr_bank), 32'd0);
    checkOutput("idle_start_rd_bank", 32'(rd_bank), 32'd1);
    for (int i = 0; i < LAST_A; i++) applyStimulus(1'b0, 1'b1, 8'(i));
    checkOutput("pre_last_addr", 32'(wr_addr), 32'(LAST_A - 1));
    applyStimulus(1'b1, 1'b1, 8'hC3);
    checkOutput("coinc_wr_en",   32'(wr_en),      32'd1);
    checkOutput("coinc_addr",    32'(wr_addr),    32'(LAST_A));
    checkOutput("coinc_data",    32'(wr_data),    32'hC3);
    checkOutput("coinc_done",    32'(frame_done), 32'd1);
    checkOutput("coinc_wr_bank", 32'(wr_bank),    32'd1);
    checkOutput("coinc_rd_bank", 32'(rd_bank),    32'd0);
    checkOutput("coinc_busy",    32'(busy),       32'd1);
    checkOutput("coinc_abort",   32'(err_abort),  32'd0);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    checkOutput("coinc_next_addr", 32'(wr_addr),    32'd0);
    checkOutput("coinc_next_done", 32'(frame_done), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
